des_key_sched: RTL and testbench

- Parametrised DES/TDES key-schedule generator.
- Accepts one 64-bit key (NUM_KEYS=1) or a three-key bundle (NUM_KEYS=3) over a valid/ready handshake, applies PC-1 once per key, then iterates the 28+28-bit rotate/PC-2 schedule in a small FSM.
- Emits 16*NUM_KEYS 48-bit subkeys, one per accepted handshake, in encrypt or decrypt order.
- Feeds the round datapath; replaces per-round standalone subkey logic with one backpressured, mode-aware schedule engine.

---
 rtl/des_pkg.sv | 73 +++++++
 rtl/des_key_cd_step.sv | 18 +
 rtl/des_key_sched.sv | 151 +++++++++++++++
 tb/tb_des_key_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants, types and bit-permutation helpers shared by
// the schedule engine and the CD rotation step. Bit 1 of every DES vector is the MSB.
package des_pkg;

  typedef logic [55:0] cd_t;
  typedef logic [47:0] subkey_t;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int unsigned PC1_IDX [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_IDX [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Decrypt starts with a zero shift: PC1 output already equals C16/D16.
  localparam logic [1:0] ENC_SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_SHIFT [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic cd_t pc1(input logic [63:0] key);
    cd_t cd;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_IDX[6'(i)])];
    end
    return cd;
  endfunction

  function automatic subkey_t pc2(input cd_t cd);
    subkey_t sk;
    for (int i = 0; i < 48; i++) begin
      sk[6'(47 - i)] = cd[6'(56 - PC2_IDX[6'(i)])];
    end
    return sk;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_cd_step.sv
// Combinational next-CD: rotates the C and D halves by the same amount,
// left for encrypt order and right for decrypt order.
module des_key_cd_step
  import des_pkg::*;
(
  input  cd_t        cd_i,
  input  logic [1:0] amt_i,
  input  logic       dir_right_i,
  output cd_t        cd_o
);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_half
    assign cd_o[28*gi +: 28] = dir_right_i ? rotr28(cd_i[28*gi +: 28], amt_i)
                                           : rotl28(cd_i[28*gi +: 28], amt_i);
  end

endmodule

// File: rtl/des_key_sched.sv
// DES/TDES key-schedule engine: one subkey per sk handshake, encrypt or decrypt order.
// Optional key parity check built when DES_KEY_PARITY_CHK_EN is defined.
module des_key_sched
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1,
  parameter int ROUNDS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic                  decrypt,
  output logic                  sk_valid,
  input  logic                  sk_ready,
  output logic [47:0]           sk_data,
  output logic [3:0]            sk_round,
  output logic [1:0]            sk_seg,
  output logic                  sk_last,
  output logic                  par_err
);

  localparam int         KW       = 64 * NUM_KEYS;
  localparam int         K2_HI    = (NUM_KEYS > 1) ? 127 : 63;
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [1:0] LAST_SEG = 2'(NUM_KEYS - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic          dec_q, dec_d;
  cd_t           cd_q, cd_d;
  logic [3:0]    round_q, round_d;
  logic [1:0]    seg_q, seg_d;

  logic          run, accept, fire;
  logic          ld, ld_dec, seg_dec;
  logic [KW-1:0] ld_bundle;
  logic [1:0]    ld_seg, kidx, amt;
  logic [63:0]   ld_key;
  logic [3:0]    tbl_idx;
  cd_t           step_in, step_out;

  assign run    = (state_q == ST_RUN);
  assign accept = !run && key_valid;
  assign fire   = run && sk_ready;

  always_comb begin : load_mux
    // Outside IDLE the only load is the change to the next segment key.
    ld        = !run || (round_q == LAST_RND);
    ld_bundle = run ? key_q : key_in;
    ld_dec    = run ? dec_q : decrypt;
    ld_seg    = run ? seg_q + 2'd1 : 2'd0;
    kidx      = ld_dec ? LAST_SEG - ld_seg : ld_seg;
    case (kidx)
      2'd0:    ld_key = ld_bundle[KW-1 -: 64];
      2'd1:    ld_key = ld_bundle[K2_HI -: 64];
      default: ld_key = ld_bundle[63:0];
    endcase
    // TDES EDE: the middle segment runs in the opposite direction.
    seg_dec = ld ? (ld_dec ^ ld_seg[0]) : (dec_q ^ seg_q[0]);
    tbl_idx = ld ? 4'd0 : round_q + 4'd1;
    amt     = seg_dec ? DEC_SHIFT[tbl_idx] : ENC_SHIFT[tbl_idx];
    step_in = ld ? pc1(ld_key) : cd_q;
  end

  des_key_cd_step u_step (
    .cd_i        (step_in),
    .amt_i       (amt),
    .dir_right_i (seg_dec),
    .cd_o        (step_out)
  );

  always_comb begin : next_state
    state_d = state_q;
    key_d   = key_q;
    dec_d   = dec_q;
    cd_d    = cd_q;
    round_d = round_q;
    seg_d   = seg_q;
    if (accept) begin
      state_d = ST_RUN;
      key_d   = key_in;
      dec_d   = decrypt;
      cd_d    = step_out;
      round_d = 4'd0;
      seg_d   = 2'd0;
    end else if (fire) begin
      if (round_q != LAST_RND) begin
        cd_d    = step_out;
        round_d = round_q + 4'd1;
      end else if (seg_q != LAST_SEG) begin
        cd_d    = step_out;
        round_d = 4'd0;
        seg_d   = seg_q + 2'd1;
      end else begin
        state_d = ST_IDLE;
        round_d = 4'd0;
        seg_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      dec_q   <= 1'b0;
      cd_q    <= '0;
      round_q <= 4'd0;
      seg_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      seg_q   <= seg_d;
    end
  end

  assign key_ready = !run;
  assign sk_valid  = run;
  assign sk_data   = run ? pc2(cd_q) : '0;
  assign sk_round  = round_q;
  assign sk_seg    = seg_q;
  assign sk_last   = run && (seg_q == LAST_SEG) && (round_q == LAST_RND);

`ifdef DES_KEY_PARITY_CHK_EN
  logic [8*NUM_KEYS-1:0] byte_even;
  logic                  par_err_q;

  genvar gi;
  for (gi = 0; gi < 8 * NUM_KEYS; gi++) begin : g_par
    assign byte_even[gi] = ~^key_in[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= |byte_even;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: a reference DES key schedule drives
// per-cycle checks on a single-key and a three-key instance.
module tb_des_key_sched;

  localparam logic [63:0] K_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] K_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K_C = 64'h0123456789ABCDEF;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic [47:0] d;
    logic [3:0]  r;
    logic [1:0]  s;
    logic        l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         kv1 = 1'b0, dec1 = 1'b0, skr1 = 1'b1;
  logic [63:0]  ki1 = '0;
  logic         kr1, sv1, sl1, pe1;
  logic [47:0]  sd1;
  logic [3:0]   srd1;
  logic [1:0]   ssg1;
  logic         kv3 = 1'b0, dec3 = 1'b0, skr3 = 1'b1;
  logic [191:0] ki3 = '0;
  logic         kr3, sv3, sl3, pe3;
  logic [47:0]  sd3;
  logic [3:0]   srd3;
  logic [1:0]   ssg3;

  int   n_vec = 0;
  int   n_miss = 0;
  logic chk_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic par_exp1 = 1'b0, par_exp3 = 1'b0;
  int   cnt;

  always #5 clk = ~clk;

  des_key_sched #(.NUM_KEYS(1), .ROUNDS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv1), .key_ready(kr1), .key_in(ki1),
    .decrypt(dec1), .sk_valid(sv1), .sk_ready(skr1), .sk_data(sd1),
    .sk_round(srd1), .sk_seg(ssg1), .sk_last(sl1), .par_err(pe1)
  );

  des_key_sched #(.NUM_KEYS(3), .ROUNDS(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv3), .key_ready(kr3), .key_in(ki3),
    .decrypt(dec3), .sk_valid(sv3), .sk_ready(skr3), .sk_data(sd3),
    .sk_round(srd3), .sk_seg(ssg3), .sk_last(sl3), .par_err(pe3)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Textbook schedule: K_i = PC2 of C0/D0 rotated left by the cumulative shift.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int i);
    logic [56:1] cd0, cdi;
    logic [47:0] k;
    int t;
    for (int j = 1; j <= 56; j++) cd0[j] = key[64 - PC1_T[j-1]];
    t = 0;
    for (int r = 1; r <= i; r++) t += SH_T[r-1];
    for (int j = 1; j <= 28; j++) begin
      cdi[j]      = cd0[((j - 1 + t) % 28) + 1];
      cdi[28 + j] = cd0[28 + ((j - 1 + t) % 28) + 1];
    end
    for (int m = 0; m < 48; m++) k[47 - m] = cdi[PC2_T[m]];
    return k;
  endfunction

  // n-th subkey emitted for a bundle (K1 = k1), decrypt order = reversed list.
  function automatic exp_t exp_item(input logic [63:0] k1, input logic [63:0] k2,
                                    input logic [63:0] k3, input int nk,
                                    input logic dec, input int n);
    exp_t e;
    int s, r;
    logic [63:0] key;
    logic mode;
    s = n / 16;
    r = n % 16;
    if (nk == 1) begin
      key = k1; mode = dec;
    end else if (!dec) begin
      key = (s == 0) ? k1 : (s == 1) ? k2 : k3; mode = (s == 1);
    end else begin
      key = (s == 0) ? k3 : (s == 1) ? k2 : k1; mode = (s != 1);
    end
    e.d = ref_subkey(key, mode ? 16 - r : r + 1);
    e.r = 4'(r);
    e.s = 2'(s);
    e.l = (n == 16 * nk - 1);
    return e;
  endfunction

  function automatic logic any_even(input logic [191:0] b, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (($countones(b[8*i +: 8]) % 2) == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut1 key_ready", 64'(kr1), 64'(q1.size() == 0));
      check("dut1 sk_valid", 64'(sv1), 64'(q1.size() != 0));
      check("dut1 par_err", 64'(pe1), 64'(par_exp1));
      if (q1.size() != 0 && sv1) begin
        e1 = q1[0];
        check("dut1 sk_data", 64'(sd1), 64'(e1.d));
        check("dut1 sk_round", 64'(srd1), 64'(e1.r));
        check("dut1 sk_seg", 64'(ssg1), 64'(e1.s));
        check("dut1 sk_last", 64'(sl1), 64'(e1.l));
      end
      if (!rst_n) begin
        q1.delete();
        par_exp1 = 1'b0;
      end else if (q1.size() != 0) begin
        if (skr1) void'(q1.pop_front());
      end else if (kv1) begin
        for (int n = 0; n < 16; n++) q1.push_back(exp_item(ki1, 64'h0, 64'h0, 1, dec1, n));
`ifdef DES_KEY_PARITY_CHK_EN
        par_exp1 = any_even({128'h0, ki1}, 8);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut3 key_ready", 64'(kr3), 64'(q3.size() == 0));
      check("dut3 sk_valid", 64'(sv3), 64'(q3.size() != 0));
      check("dut3 par_err", 64'(pe3), 64'(par_exp3));
      if (q3.size() != 0 && sv3) begin
        e3 = q3[0];
        check("dut3 sk_data", 64'(sd3), 64'(e3.d));
        check("dut3 sk_round", 64'(srd3), 64'(e3.r));
        check("dut3 sk_seg", 64'(ssg3), 64'(e3.s));
        check("dut3 sk_last", 64'(sl3), 64'(e3.l));
      end
      if (!rst_n) begin
        q3.delete();
        par_exp3 = 1'b0;
      end else if (q3.size() != 0) begin
        if (skr3) void'(q3.pop_front());
      end else if (kv3) begin
        for (int n = 0; n < 48; n++)
          q3.push_back(exp_item(ki3[191:128], ki3[127:64], ki3[63:0], 3, dec3, n));
`ifdef DES_KEY_PARITY_CHK_EN
        par_exp3 = any_even(ki3, 24);
`endif
      end
    end
  end

  // Called at posedge+1 with the engine idle; returns at posedge+1 after acceptance.
  task automatic send1(input logic [63:0] key, input logic dec);
    kv1 = 1'b1; ki1 = key; dec1 = dec;
    @(posedge clk); #1;
    kv1 = 1'b0;
  endtask

  task automatic send3(input logic [191:0] keys, input logic dec);
    kv3 = 1'b1; ki3 = keys; dec3 = dec;
    @(posedge clk); #1;
    kv3 = 1'b0;
  endtask

  task automatic wait_idle;
    skr1 = 1'b1; skr3 = 1'b1; kv1 = 1'b0; kv3 = 1'b0;
    for (int c = 0; c < 400 && (q1.size() != 0 || q3.size() != 0); c++) @(posedge clk);
    @(posedge clk); #1;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL idle_timeout: got %0d/%0d pending, expected 0", q1.size(), q3.size());
    end
  endtask

  task automatic count_valid1(input int exp_n, input string nm);
    cnt = 0;
    for (int c = 0; c < exp_n + 4; c++) begin
      if (sv1) cnt++;
      @(posedge clk); #1;
    end
    check(nm, 64'(cnt), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic par_zero_exp;
`ifdef DES_KEY_PARITY_CHK_EN
    par_zero_exp = 1'b1;
`else
    par_zero_exp = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset key_ready", 64'(kr1), 64'd1);
    check("reset sk_valid", 64'(sv1), 64'd0);
    check("reset sk_data", 64'(sd1), 64'd0);
    check("reset sk_round", 64'(srd1), 64'd0);
    check("reset sk_seg", 64'(ssg1), 64'd0);
    check("reset sk_last", 64'(sl1), 64'd0);
    check("reset par_err", 64'(pe1), 64'd0);
    check("reset3 sk_valid", 64'(sv3), 64'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;

    check("model K1", 64'(ref_subkey(K_A, 1)), 64'h1B02EFFC7072);
    check("model K2", 64'(ref_subkey(K_A, 2)), 64'h79AED9DBC9E5);
    check("model K16", 64'(ref_subkey(K_A, 16)), 64'hCB3D8B0E17F5);
    check("model zero key", 64'(ref_subkey(64'h0, 7)), 64'h0);

    @(posedge clk); #1;
    send1(K_A, 1'b0);
    check("enc first sk_data", 64'(sd1), 64'h1B02EFFC7072);
    check("enc par_err", 64'(pe1), 64'd0);
    count_valid1(16, "enc valid cycles");
    wait_idle();

    send1(K_A, 1'b1);
    check("dec first sk_data", 64'(sd1), 64'hCB3D8B0E17F5);
    check("dec first sk_round", 64'(srd1), 64'd0);
    count_valid1(16, "dec valid cycles");
    wait_idle();

    send1(K_B, 1'b0);
    for (int c = 0; c < 120; c++) begin
      skr1 = 1'($urandom_range(0, 1));
      kv1 = 1'b1; ki1 = K_C; dec1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wait_idle();

    send3({K_A, K_B, K_A}, 1'b0);
    cnt = 0;
    for (int c = 0; c < 52; c++) begin
      if (sv3) cnt++;
      @(posedge clk); #1;
    end
    check("tdes valid cycles", 64'(cnt), 64'd48);
    wait_idle();

    send3({K_A, K_B, K_C}, 1'b1);
    for (int c = 0; c < 100; c++) begin
      skr3 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wait_idle();

    send1(K_B, 1'b0);
    for (int c = 0; c < 40 && !(sv1 && srd1 == 4'd6); c++) begin
      @(posedge clk); #1;
    end
    check("reached round 7", 64'(srd1), 64'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun reset sk_valid", 64'(sv1), 64'd0);
    check("midrun reset key_ready", 64'(kr1), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send1(K_A, 1'b0);
    check("after reset sk_round", 64'(srd1), 64'd0);
    check("after reset sk_data", 64'(sd1), 64'h1B02EFFC7072);
    wait_idle();

    send1(64'h0, 1'b0);
    check("zero key par_err", 64'(pe1), 64'(par_zero_exp));
    check("zero key sk_data", 64'(sd1), 64'h0);
    count_valid1(16, "zero key valid cycles");
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
